// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequencer: display modes and bounce direction.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_GROUP     = 2'd0,
        MODE_REPLICATE = 2'd1,
        MODE_BOUNCE    = 2'd2,
        MODE_FILL      = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_seq_prescaler.sv
// Free-running prescaler: one step every 2^DIV_W enabled clocks, plus a
// registered one-cycle tick strobe aligned with the state update.
module led_seq_prescaler #(
    parameter int DIV_W = 23
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic step,
    output logic tick_o
);

    logic [DIV_W-1:0] div_p0;

    assign step = en_i && (&div_p0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_p0 <= '0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= step;
            if (step) begin
                div_p0 <= '0;
            end else if (en_i) begin
                div_p0 <= div_p0 + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: GROUP / REPLICATE / BOUNCE / FILL patterns advanced
// once per prescaler step; mode changes take effect only on a step edge.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int DIV_W = 23,
    parameter int LED_N = 12,
    parameter int GRP_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    output logic [LED_N-1:0] led,
    output logic             tick_o
);

    localparam int NGRP   = LED_N / GRP_W;
    localparam int SEL_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int CNT_W  = GRP_W + SEL_W;
    localparam int POS_W  = (LED_N > 1) ? $clog2(LED_N) : 1;
    localparam int FILL_W = $clog2(LED_N + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NGRP * (2 ** GRP_W) - 1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(LED_N - 1);
    localparam logic [POS_W-1:0]  POS_PREV  = POS_W'((LED_N > 1) ? LED_N - 2 : 0);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LED_N);

    logic              step;
    mode_e             mode_q,  mode_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [POS_W-1:0]  pos_q,   pos_d;
    dir_e              dir_q,   dir_d;
    logic [FILL_W-1:0] fill_q,  fill_d;

    led_seq_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .step   (step),
        .tick_o (tick_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_GROUP;
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= DIR_UP;
            fill_q <= '0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            fill_q <= fill_d;
        end
    end

    // A differing request on a step edge restarts the pattern instead of advancing it.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        fill_d = fill_q;
        if (step) begin
            if (mode_e'(mode_i) != mode_q) begin
                mode_d = mode_e'(mode_i);
                cnt_d  = '0;
                pos_d  = '0;
                dir_d  = DIR_UP;
                fill_d = '0;
            end else begin
                case (mode_q)
                    MODE_GROUP, MODE_REPLICATE: begin
                        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                    end
                    MODE_BOUNCE: begin
                        if (LED_N > 1) begin
                            if (dir_q == DIR_UP) begin
                                if (pos_q == POS_LAST) begin
                                    dir_d = DIR_DOWN;
                                    pos_d = POS_PREV;
                                end else begin
                                    pos_d = pos_q + POS_W'(1);
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    dir_d = DIR_UP;
                                    pos_d = POS_W'(1);
                                end else begin
                                    pos_d = pos_q - POS_W'(1);
                                end
                            end
                        end
                    end
                    MODE_FILL: begin
                        fill_d = (fill_q == FILL_LAST) ? '0 : fill_q + FILL_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        led = '0;
        case (mode_q)
            MODE_GROUP: begin
                for (int g = 0; g < NGRP; g++) begin
                    if (cnt_q[CNT_W-1 -: SEL_W] == SEL_W'(g)) begin
                        led[g*GRP_W +: GRP_W] = cnt_q[GRP_W-1:0];
                    end
                end
            end
            MODE_REPLICATE: begin
                for (int g = 0; g < NGRP; g++) begin
                    led[g*GRP_W +: GRP_W] = cnt_q[GRP_W-1:0];
                end
            end
            MODE_BOUNCE: begin
                for (int i = 0; i < LED_N; i++) begin
                    led[i] = (pos_q == POS_W'(i));
                end
            end
            MODE_FILL: begin
                for (int i = 0; i < LED_N; i++) begin
                    led[i] = (FILL_W'(i) < fill_q);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized and directed bench for led_sequencer against a closed-form
// pattern model indexed by steps since the last mode load.
module tb_led_sequencer;

    localparam int DIV_W = 2;
    localparam int LN    = 12;
    localparam int GW    = 4;
    localparam int NG    = LN / GW;
    localparam int SPC   = 1 << DIV_W;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_i  = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic [LN-1:0] led;
    logic          tick_o;

    int total = 0;
    int bad   = 0;

    int   m_en_cnt = 0;
    int   m_mode   = 0;
    int   m_k      = 0;
    logic m_tick   = 1'b0;

    led_sequencer #(
        .DIV_W (DIV_W),
        .LED_N (LN),
        .GRP_W (GW)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .mode_i (mode_i),
        .led    (led),
        .tick_o (tick_o)
    );

    always #5 clk_i = ~clk_i;

    // Pattern for mode m after k steps since it was loaded.
    function automatic logic [LN-1:0] led_ref(input int m, input int k);
        int c, p, pos, f;
        case (m)
            0: begin
                c = k % (NG * 16);
                return LN'((c % 16) << (GW * (c / 16)));
            end
            1: begin
                c = k % 16;
                return LN'(c * 'h111);
            end
            2: begin
                p = k % (2 * (LN - 1));
                pos = (p <= LN - 1) ? p : 2 * (LN - 1) - p;
                return LN'(1 << pos);
            end
            default: begin
                f = k % (LN + 1);
                return LN'((1 << f) - 1);
            end
        endcase
    endfunction

    task automatic cycle();
        @(posedge clk_i);
        if (rst_i) begin
            m_en_cnt = 0;
            m_mode   = 0;
            m_k      = 0;
            m_tick   = 1'b0;
        end else if (en_i) begin
            m_en_cnt++;
            m_tick = (m_en_cnt % SPC == 0);
            if (m_tick) begin
                if (int'(mode_i) != m_mode) begin
                    m_mode = int'(mode_i);
                    m_k    = 0;
                end else begin
                    m_k++;
                end
            end
        end else begin
            m_tick = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        rst_i  = 1'b1;
        en_i   = 1'b1;
        mode_i = m;
        cycle();
        rst_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i  = 1'b1;
        en_i   = 1'b1;
        mode_i = 2'($urandom_range(0, 3));
        cycle();
        cycle();
        total++;
        if (led !== '0) begin
            bad++;
            $display("FAIL reset_led got=%h exp=%h", led, {LN{1'b0}});
        end
        total++;
        if (tick_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_tick got=%b exp=0", tick_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_first_ticks();
        logic [LN-1:0] exp_led [4] = '{12'h001, 12'h002, 12'h003, 12'h004};
        do_reset(2'd0);
        mode_i = 2'd0;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            total++;
            if (tick_o !== ((i % 4) == 0)) begin
                bad++;
                $display("FAIL first_tick clk=%0d got=%b exp=%b", i, tick_o, (i % 4) == 0);
            end
            if ((i % 4) == 0) begin
                total++;
                if (led !== exp_led[i/4-1]) begin
                    bad++;
                    $display("FAIL first_led clk=%0d got=%h exp=%h", i, led, exp_led[i/4-1]);
                end
            end
        end
    endtask

    task automatic test_group_wrap();
        do_reset(2'd0);
        for (int s = 1; s <= 48; s++) begin
            for (int c = 0; c < SPC; c++) begin
                cycle();
                total++;
                if (led !== led_ref(m_mode, m_k) || tick_o !== m_tick) begin
                    bad++;
                    $display("FAIL group step=%0d led=%h exp=%h tick=%b exp=%b",
                             s, led, led_ref(m_mode, m_k), tick_o, m_tick);
                end
            end
            if (s == 47) begin
                total++;
                if (led !== 12'hF00) begin
                    bad++;
                    $display("FAIL group_47 got=%h exp=f00", led);
                end
            end
            if (s == 48) begin
                total++;
                if (led !== 12'h000) begin
                    bad++;
                    $display("FAIL group_wrap got=%h exp=000", led);
                end
            end
        end
    endtask

    task automatic test_bounce();
        do_reset(2'd2);
        for (int s = 1; s <= 30; s++) begin
            for (int c = 0; c < SPC; c++) begin
                cycle();
                total++;
                if (led !== led_ref(m_mode, m_k) || tick_o !== m_tick) begin
                    bad++;
                    $display("FAIL bounce step=%0d led=%h exp=%h tick=%b exp=%b",
                             s, led, led_ref(m_mode, m_k), tick_o, m_tick);
                end
            end
            if (s == 1 || s == 13) begin
                total++;
                if (led !== ((s == 1) ? 12'h001 : 12'h400)) begin
                    bad++;
                    $display("FAIL bounce_end step=%0d got=%h exp=%h", s, led,
                             (s == 1) ? 12'h001 : 12'h400);
                end
            end
        end
    endtask

    task automatic test_fill_midchange();
        logic [LN-1:0] held;
        do_reset(2'd3);
        for (int s = 0; s <= 13; s++) begin
            for (int c = 0; c < SPC; c++) begin
                cycle();
                total++;
                if (led !== led_ref(m_mode, m_k)) begin
                    bad++;
                    $display("FAIL fill step=%0d got=%h exp=%h", s, led, led_ref(m_mode, m_k));
                end
            end
            if (s == 12 || s == 13) begin
                total++;
                if (led !== ((s == 12) ? 12'hFFF : 12'h000)) begin
                    bad++;
                    $display("FAIL fill_end step=%0d got=%h exp=%h", s, led,
                             (s == 12) ? 12'hFFF : 12'h000);
                end
            end
        end
        held = led_ref(m_mode, m_k);
        mode_i = 2'd1;
        for (int c = 1; c <= SPC; c++) begin
            cycle();
            total++;
            if (c < SPC && (led !== held || tick_o !== 1'b0)) begin
                bad++;
                $display("FAIL midchange clk=%0d led=%h exp=%h tick=%b exp=0", c, led, held, tick_o);
            end else if (c == SPC && (led !== 12'h000 || tick_o !== 1'b1)) begin
                bad++;
                $display("FAIL midchange_load led=%h exp=000 tick=%b exp=1", led, tick_o);
            end
        end
    endtask

    task automatic test_freeze();
        logic [LN-1:0] held;
        int wait_clks;
        do_reset(2'd0);
        for (int c = 0; c < SPC + 2; c++) cycle();
        held = led_ref(m_mode, m_k);
        en_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            total++;
            if (led !== held || tick_o !== 1'b0) begin
                bad++;
                $display("FAIL freeze clk=%0d led=%h exp=%h tick=%b exp=0", c, led, held, tick_o);
            end
        end
        en_i = 1'b1;
        wait_clks = 0;
        do begin
            cycle();
            wait_clks++;
        end while (tick_o !== 1'b1 && wait_clks < 2 * SPC);
        total++;
        if (wait_clks != SPC - 2 || led !== led_ref(m_mode, m_k)) begin
            bad++;
            $display("FAIL freeze_resume clks=%0d exp=%0d led=%h exp=%h",
                     wait_clks, SPC - 2, led, led_ref(m_mode, m_k));
        end
    endtask

    task automatic test_reset_on_step();
        do_reset(2'd1);
        for (int c = 0; c < 3 * SPC - 1; c++) cycle();
        rst_i = 1'b1;
        cycle();
        rst_i  = 1'b0;
        total++;
        if (led !== 12'h000 || tick_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_step led=%h exp=000 tick=%b exp=0", led, tick_o);
        end
        mode_i = 2'd0;
        for (int c = 0; c < SPC; c++) cycle();
        total++;
        if (led !== 12'h001 || tick_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_step_mode led=%h exp=001 tick=%b exp=1", led, tick_o);
        end
    endtask

    task automatic test_random();
        do_reset(2'd0);
        for (int i = 0; i < 3000; i++) begin
            rst_i = ($urandom_range(0, 199) == 0);
            en_i  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) mode_i = 2'($urandom_range(0, 3));
            cycle();
            total++;
            if (led !== led_ref(m_mode, m_k) || tick_o !== m_tick) begin
                bad++;
                $display("FAIL random i=%0d mode=%0d k=%0d led=%h exp=%h tick=%b exp=%b",
                         i, m_mode, m_k, led, led_ref(m_mode, m_k), tick_o, m_tick);
            end
        end
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_ticks();
        test_group_wrap();
        test_bounce();
        test_fill_midchange();
        test_freeze();
        test_reset_on_step();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
